udma_uart_rx_buf: RTL

Parametrised UART receive engine with integrated RX FIFO and event generation. It is the next generation of the uDMA UART receive path, running entirely in the peripheral clock domain. It adds:
- 3-sample majority voting
- selectable odd/even parity
- break and framing detection
- configurable FIFO depth, fill-level watermark and idle timeout

Its output stream feeds the uDMA RX channel or a register-polling interface.

---
 rtl/udma_uart_rx_buf.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/udma_uart_rx_buf.sv
// UART receive engine: 3-sample majority voting, parity/frame/break detection,
// RX FIFO with character, watermark and idle-timeout events.
module udma_uart_rx_buf #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 rx_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_bits_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_parity_odd_i,
  input  logic                 cfg_stop_bits_i,
  input  logic                 cfg_clr_i,
  input  logic [LVL_W-1:0]     cfg_watermark_i,
  input  logic [7:0]           cfg_timeout_i,
  output logic [7:0]           data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [LVL_W-1:0]     fifo_level_o,
  output logic                 busy_o,
  output logic                 char_event_o,
  output logic                 watermark_event_o,
  output logic                 timeout_event_o,
  output logic                 err_parity_o,
  output logic                 err_frame_o,
  output logic                 err_break_o,
  output logic                 err_overflow_o
);
  localparam int PTR_W = LVL_W - 1;
  localparam logic [DIV_WIDTH:0]   ONE_X   = 1;
  localparam logic [DIV_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [LVL_W-1:0]     LVL_ONE = 1;
  localparam logic [LVL_W-1:0]     DEPTH_L = FIFO_DEPTH;
  localparam logic [PTR_W-1:0]     PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK
  } state_e;

  logic                 sync1_q, rxs_q, rxs_prev_q;
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [1:0]           bits_q, bits_d;
  logic                 par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic                 push_q, push_d, brk_q, brk_d;
  logic                 s0_q, s1_q;
  logic [7:0]           shreg_q, shreg_d, push_data_q;
  logic                 push_perr_q, push_ferr_q;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 wm_ev_q, wm_ev_d;
  logic [DIV_WIDTH-1:0] tdiv_q, tdiv_d;
  logic [7:0]           tcnt_q, tcnt_d;
  logic                 armed_q, armed_d, to_ev_q, to_ev_d;

  logic [DIV_WIDTH:0]   half, cnt_x;
  logic                 at_a, at_b, at_c, wrap, maj, fall, is_brk, exp_par;
  logic [2:0]           last_idx;
  logic                 pop, full, accept, run, tick, kick;

  assign half     = ({1'b0, div_q} + ONE_X) >> 1;
  assign cnt_x    = {1'b0, cnt_q};
  assign at_a     = (cnt_x == half - ONE_X);
  assign at_b     = (cnt_x == half);
  assign at_c     = (cnt_x == half + ONE_X);
  assign wrap     = (cnt_q == div_q);
  assign maj      = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign fall     = rxs_prev_q & ~rxs_q;
  assign last_idx = {1'b0, bits_q} + 3'd4;
  assign exp_par  = (^shreg_q) ^ par_odd_q;
  assign is_brk   = ~maj & (shreg_q == 8'h00) & ~par_err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = wrap ? '0 : cnt_q + CNT_ONE;
    div_d     = div_q;
    bits_d    = bits_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    bit_idx_d = bit_idx_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    shreg_d   = shreg_q;
    push_d    = 1'b0;
    brk_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall && cfg_en_i) begin
          // The edge-detect cycle itself is count 0 of the start bit.
          state_d   = S_START;
          cnt_d     = CNT_ONE;
          div_d     = cfg_div_i;
          bits_d    = cfg_bits_i;
          par_en_d  = cfg_parity_en_i;
          par_odd_d = cfg_parity_odd_i;
          stop2_d   = cfg_stop_bits_i;
          bit_idx_d = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
          shreg_d   = '0;
        end
      end
      S_START: begin
        if (at_c && maj) state_d = S_IDLE;
        else if (wrap)   state_d = S_DATA;
      end
      S_DATA: begin
        if (at_c) shreg_d[bit_idx_q] = maj;
        if (wrap) begin
          if (bit_idx_q == last_idx) state_d = par_en_q ? S_PARITY : S_STOP1;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (at_c) par_err_d = maj ^ exp_par;
        if (wrap) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (at_c && is_brk) begin
          brk_d   = 1'b1;
          state_d = S_BREAK;
        end else begin
          if (at_c) frm_err_d = frm_err_q | ~maj;
          if (at_c && !stop2_q) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else if (wrap && stop2_q) begin
            state_d = S_STOP2;
          end
        end
      end
      S_STOP2: begin
        if (at_c) begin
          frm_err_d = frm_err_q | ~maj;
          push_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!cfg_en_i) begin
      state_d = S_IDLE;
      push_d  = 1'b0;
      brk_d   = 1'b0;
    end
  end

  // FIFO: clear wins over push/pop; a full FIFO still accepts when popped this cycle.
  assign pop    = valid_o & ready_i;
  assign full   = (level_q == DEPTH_L);
  assign accept = push_q & (~full | pop) & ~cfg_clr_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (cfg_clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (accept) wptr_d = wptr_q + PTR_ONE;
      if (pop)    rptr_d = rptr_q + PTR_ONE;
      if (accept && !pop)      level_d = level_q + LVL_ONE;
      else if (!accept && pop) level_d = level_q - LVL_ONE;
    end
    wm_ev_d = (cfg_watermark_i != '0) && (level_q < cfg_watermark_i) &&
              (level_d >= cfg_watermark_i);
  end

  assign run  = (state_q == S_IDLE) && valid_o && (cfg_timeout_i != 8'd0) && armed_q;
  assign tick = (tdiv_q >= cfg_div_i);
  assign kick = accept | pop | cfg_clr_i;

  always_comb begin
    tdiv_d  = tdiv_q;
    tcnt_d  = tcnt_q;
    armed_d = armed_q;
    to_ev_d = 1'b0;
    if (kick) begin
      tdiv_d  = '0;
      tcnt_d  = '0;
      armed_d = 1'b1;
    end else if (run) begin
      if (tick) begin
        tdiv_d = '0;
        if (tcnt_q + 8'd1 == cfg_timeout_i) begin
          to_ev_d = 1'b1;
          armed_d = 1'b0;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end else begin
        tdiv_d = tdiv_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bits_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      bit_idx_q  <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      push_q     <= 1'b0;
      brk_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      wm_ev_q    <= 1'b0;
      tdiv_q     <= '0;
      tcnt_q     <= '0;
      armed_q    <= 1'b0;
      to_ev_q    <= 1'b0;
    end else begin
      sync1_q    <= rx_i;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bits_q     <= bits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      bit_idx_q  <= bit_idx_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      push_q     <= push_d;
      brk_q      <= brk_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      wm_ev_q    <= wm_ev_d;
      tdiv_q     <= tdiv_d;
      tcnt_q     <= tcnt_d;
      armed_q    <= armed_d;
      to_ev_q    <= to_ev_d;
    end
  end

  // Datapath registers: only meaningful when qualified by the control flops above.
  always_ff @(posedge clk_i) begin
    if (at_a) s0_q <= rxs_q;
    if (at_b) s1_q <= rxs_q;
    shreg_q     <= shreg_d;
    push_data_q <= shreg_q;
    push_perr_q <= par_err_q;
    push_ferr_q <= frm_err_d;
    if (accept) mem_q[wptr_q] <= push_data_q;
  end

  assign valid_o           = (level_q != '0);
  assign data_o            = valid_o ? mem_q[rptr_q] : 8'h00;
  assign fifo_level_o      = level_q;
  assign busy_o            = (state_q != S_IDLE);
  assign char_event_o      = accept;
  assign err_overflow_o    = push_q & full & ~pop & ~cfg_clr_i;
  assign err_parity_o      = push_q & push_perr_q;
  assign err_frame_o       = push_q & push_ferr_q;
  assign err_break_o       = brk_q;
  assign watermark_event_o = wm_ev_q;
  assign timeout_event_o   = to_ev_q;

endmodule
